// File: rtl/dct_ch_arb_pkg.sv
// Shared constants and types for the DCT channel arbiter.
package dct_ch_arb_pkg;

  localparam int DCT_LAT      = 8;
  localparam int ROWS_PER_BLK = 8;
  localparam int SAMP_PER_ROW = 8;
  localparam int W_I_DEF      = 8;
  localparam int MAX_CH       = 8;

  typedef logic [$clog2(MAX_CH)-1:0] ch_id_t;
  typedef logic [SAMP_PER_ROW-1:0][W_I_DEF-1:0] row_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

endpackage

// File: rtl/dct_ch_arb_rr_pick.sv
// Round-robin picker: first eligible channel strictly after ptr, wrapping.
module dct_ch_arb_rr_pick #(
  parameter int N_CH = 3,
  parameter int CH_W = $clog2(N_CH)
) (
  input  logic [CH_W-1:0] ptr,
  input  logic [N_CH-1:0] eligible,
  output logic [N_CH-1:0] grant_oh,
  output logic [CH_W-1:0] grant_idx,
  output logic            grant_any
);

  int              c;
  logic [CH_W-1:0] cand;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    c         = 0;
    cand      = '0;
    for (int i = 1; i <= N_CH; i++) begin
      c    = (int'(ptr) + i) % N_CH;
      cand = c[CH_W-1:0];
      if (!grant_any && eligible[cand]) begin
        grant_any      = 1'b1;
        grant_idx      = cand;
        grant_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dct_ch_arb.sv
// Block-atomic round-robin arbiter feeding one row DCT, with framing regeneration
// and a channel tag delayed to line up with the DCT output.
//   state   | meaning
//   IDLE    | no block open; sob rows compete, non-sob rows are dropped as errors
//   BUSY    | block owned by g_q; row_cnt_q is index of the next row (1..7)
module dct_ch_arb
  import dct_ch_arb_pkg::*;
#(
  parameter  int W_I  = 8,
  parameter  int N_CH = 3,
  parameter  int LAT  = DCT_LAT,
  localparam int CH_W = $clog2(N_CH)
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic [N_CH-1:0]                       req_valid,
  input  logic [N_CH-1:0][SAMP_PER_ROW-1:0][W_I-1:0] req_data,
  input  logic [N_CH-1:0]                       req_sob,
  input  logic [N_CH-1:0]                       req_eob,
  input  logic [N_CH-1:0]                       req_sof,
  output logic [N_CH-1:0]                       req_ready,
  output logic                                  dct_valid,
  output logic [SAMP_PER_ROW-1:0][W_I-1:0]      dct_data,
  output logic                                  dct_sob,
  output logic                                  dct_eob,
  output logic                                  dct_sof,
  output logic                                  tag_valid,
  output logic [CH_W-1:0]                       tag_ch,
  output logic [N_CH-1:0]                       err
);

  arb_state_t                         state_q, state_d;
  logic [CH_W-1:0]                    g_q, g_d;
  logic [CH_W-1:0]                    rr_ptr_q, rr_ptr_d;
  logic [2:0]                         row_cnt_q, row_cnt_d;
  logic [N_CH-1:0]                    err_q, err_d;
  logic                               dct_valid_q, dct_valid_d;
  logic [SAMP_PER_ROW-1:0][W_I-1:0]   dct_data_q, dct_data_d;
  logic                               dct_sob_q, dct_sob_d;
  logic                               dct_eob_q, dct_eob_d;
  logic                               dct_sof_q, dct_sof_d;
  logic [CH_W-1:0]                    dct_ch_q, dct_ch_d;
  logic [LAT-1:0]                     tag_v_q, tag_v_d;
  logic [LAT-1:0][CH_W-1:0]           tag_c_q, tag_c_d;

  logic [N_CH-1:0] req_ready_c;
  logic [N_CH-1:0] pick_oh;
  logic [CH_W-1:0] pick_idx;
  logic            pick_any;
  logic            last_row;

  dct_ch_arb_rr_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_rr_pick (
    .ptr       (rr_ptr_q),
    .eligible  (req_valid & req_sob),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .grant_any (pick_any)
  );

  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    rr_ptr_d    = rr_ptr_q;
    row_cnt_d   = row_cnt_q;
    err_d       = err_q;
    req_ready_c = '0;
    dct_valid_d = 1'b0;
    dct_data_d  = '0;
    dct_sob_d   = 1'b0;
    dct_eob_d   = 1'b0;
    dct_sof_d   = 1'b0;
    dct_ch_d    = '0;
    last_row    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Rows arriving without sob outside a block are swallowed and flagged.
        req_ready_c = (req_valid & ~req_sob) | pick_oh;
        err_d       = err_q | (req_valid & ~req_sob);
        if (pick_any) begin
          dct_valid_d = 1'b1;
          dct_data_d  = req_data[pick_idx];
          dct_sob_d   = 1'b1;
          dct_sof_d   = req_sof[pick_idx];
          dct_ch_d    = pick_idx;
          if (req_eob[pick_idx]) err_d[pick_idx] = 1'b1;
          state_d   = ST_BUSY;
          g_d       = pick_idx;
          row_cnt_d = 3'd1;
          rr_ptr_d  = pick_idx;
        end
      end
      ST_BUSY: begin
        req_ready_c[g_q] = req_valid[g_q];
        if (req_valid[g_q]) begin
          last_row    = (row_cnt_q == 3'd7);
          dct_valid_d = 1'b1;
          dct_data_d  = req_data[g_q];
          dct_eob_d   = last_row;
          dct_ch_d    = g_q;
          if (req_sob[g_q] || (req_eob[g_q] != last_row)) err_d[g_q] = 1'b1;
          row_cnt_d = row_cnt_q + 3'd1;
          if (last_row) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    tag_v_d[0] = dct_valid_q;
    tag_c_d[0] = dct_ch_q;
    for (int i = 1; i < LAT; i++) begin
      tag_v_d[i] = tag_v_q[i-1];
      tag_c_d[i] = tag_c_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      g_q         <= '0;
      rr_ptr_q    <= CH_W'(N_CH - 1);
      row_cnt_q   <= '0;
      err_q       <= '0;
      dct_valid_q <= 1'b0;
      dct_data_q  <= '0;
      dct_sob_q   <= 1'b0;
      dct_eob_q   <= 1'b0;
      dct_sof_q   <= 1'b0;
      dct_ch_q    <= '0;
      tag_v_q     <= '0;
      tag_c_q     <= '0;
    end else begin
      state_q     <= state_d;
      g_q         <= g_d;
      rr_ptr_q    <= rr_ptr_d;
      row_cnt_q   <= row_cnt_d;
      err_q       <= err_d;
      dct_valid_q <= dct_valid_d;
      dct_data_q  <= dct_data_d;
      dct_sob_q   <= dct_sob_d;
      dct_eob_q   <= dct_eob_d;
      dct_sof_q   <= dct_sof_d;
      dct_ch_q    <= dct_ch_d;
      tag_v_q     <= tag_v_d;
      tag_c_q     <= tag_c_d;
    end
  end

  assign req_ready = req_ready_c;
  assign dct_valid = dct_valid_q;
  assign dct_data  = dct_data_q;
  assign dct_sob   = dct_sob_q;
  assign dct_eob   = dct_eob_q;
  assign dct_sof   = dct_sof_q;
  assign tag_valid = tag_v_q[LAT-1];
  assign tag_ch    = tag_c_q[LAT-1];
  assign err       = err_q;

endmodule

// File: tb/tb_dct_ch_arb.sv
// Randomized bench for dct_ch_arb against a block-level behavioural model.
module tb_dct_ch_arb;
  import dct_ch_arb_pkg::*;

  localparam int W_I  = 8;
  localparam int N_CH = 3;
  localparam int LAT  = DCT_LAT;
  localparam int CH_W = $clog2(N_CH);

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [N_CH-1:0]              req_valid, req_sob, req_eob, req_sof, req_ready;
  logic [N_CH-1:0][7:0][W_I-1:0] req_data;
  logic                         dct_valid, dct_sob, dct_eob, dct_sof, tag_valid;
  logic [7:0][W_I-1:0]          dct_data;
  logic [CH_W-1:0]              tag_ch;
  logic [N_CH-1:0]              err;

  dct_ch_arb #(.W_I(W_I), .N_CH(N_CH), .LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data), .req_sob(req_sob),
    .req_eob(req_eob), .req_sof(req_sof), .req_ready(req_ready),
    .dct_valid(dct_valid), .dct_data(dct_data), .dct_sob(dct_sob),
    .dct_eob(dct_eob), .dct_sof(dct_sof), .tag_valid(tag_valid),
    .tag_ch(tag_ch), .err(err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  // Model: block owner (-1 = none), rows taken so far, last winner.
  int              m_owner, m_rows, m_last;
  bit              e_dv, e_sob, e_eob, e_sof;
  logic [63:0]     e_data;
  int              e_ch;
  logic [N_CH-1:0] e_err;
  int              hist[$];

  // Stimulus: per-channel row index, injected faults, valid probability.
  int s_row[N_CH];
  int s_bad[N_CH];
  bit s_nosob[N_CH];
  int prob[N_CH];
  bit inj_en;

  task automatic model_reset();
    m_owner = -1; m_rows = 0; m_last = N_CH - 1;
    e_dv = 0; e_sob = 0; e_eob = 0; e_sof = 0; e_data = '0; e_ch = 0; e_err = '0;
    hist = {};
    for (int i = 0; i < LAT; i++) hist.push_back(-1);
    for (int c = 0; c < N_CH; c++) begin
      s_row[c] = 0; s_bad[c] = -1; s_nosob[c] = 0;
    end
  endtask

  task automatic check_outputs();
    int exp_tag;
    chk("dct_valid", dct_valid, e_dv);
    if (e_dv) begin
      chk("dct_data", dct_data, e_data);
      chk("dct_sob", dct_sob, e_sob);
      chk("dct_eob", dct_eob, e_eob);
      chk("dct_sof", dct_sof, e_sof);
    end
    exp_tag = hist[0];
    chk("tag_valid", tag_valid, exp_tag >= 0);
    if (exp_tag >= 0) chk("tag_ch", tag_ch, exp_tag);
    chk("err", err, e_err);
    void'(hist.pop_front());
    hist.push_back(e_dv ? e_ch : -1);
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < N_CH; c++) begin
      req_valid[c] = ($urandom_range(99) < prob[c]);
      req_data[c]  = {$urandom(), $urandom()};
      req_sob[c]   = (s_row[c] == 0) && !s_nosob[c];
      req_eob[c]   = (s_row[c] == 7) || (s_row[c] == s_bad[c]);
      req_sof[c]   = 1'($urandom_range(1));
    end
  endtask

  task automatic model_step();
    logic [N_CH-1:0] r;
    int win;
    r = '0; win = -1;
    e_dv = 0; e_sob = 0; e_eob = 0; e_sof = 0;
    if (m_owner < 0) begin
      for (int i = 1; i <= N_CH; i++) begin
        int c = (m_last + i) % N_CH;
        if (win < 0 && req_valid[c] && req_sob[c]) win = c;
      end
      for (int c = 0; c < N_CH; c++)
        if (req_valid[c] && !req_sob[c]) begin r[c] = 1'b1; e_err[c] = 1'b1; end
      if (win >= 0) begin
        r[win] = 1'b1;
        e_dv = 1; e_data = req_data[win]; e_sob = 1; e_eob = 0; e_sof = req_sof[win];
        e_ch = win;
        if (req_eob[win]) e_err[win] = 1'b1;
        m_owner = win; m_rows = 1; m_last = win;
      end
    end else begin
      r[m_owner] = req_valid[m_owner];
      if (req_valid[m_owner]) begin
        e_dv = 1; e_data = req_data[m_owner]; e_sob = 0; e_sof = 0;
        e_eob = (m_rows == 7); e_ch = m_owner;
        if (req_sob[m_owner] || (req_eob[m_owner] != (m_rows == 7))) e_err[m_owner] = 1'b1;
        m_rows++;
        if (m_rows == 8) m_owner = -1;
      end
    end
    chk("req_ready", req_ready, r);
    for (int c = 0; c < N_CH; c++) begin
      if (req_valid[c] && r[c]) begin
        if (s_row[c] == 0 && s_nosob[c]) s_nosob[c] = 0;
        else begin
          s_row[c] = (s_row[c] + 1) % 8;
          if (s_row[c] == 0) begin
            s_bad[c]   = (inj_en && $urandom_range(99) < 15) ? int'($urandom_range(6)) : -1;
            s_nosob[c] = inj_en && ($urandom_range(99) < 10);
          end
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    check_outputs();
    drive_inputs();
    #1;
    model_step();
  endtask

  task automatic run(input int n, input int p0, input int p1, input int p2, input bit inj);
    prob[0] = p0; prob[1] = p1; prob[2] = p2; inj_en = inj;
    repeat (n) cycle();
  endtask

  task automatic idle_inputs();
    req_valid = '0; req_sob = '0; req_eob = '0; req_sof = '0; req_data = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_dct_valid"}, dct_valid, 1'b0);
    chk({tag, "_dct_sob"}, dct_sob, 1'b0);
    chk({tag, "_tag_valid"}, tag_valid, 1'b0);
    chk({tag, "_err"}, err, '0);
  endtask

  initial begin
    int waited;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #12;
    check_reset_outputs("rst0");
    chk("rst0_ready", req_ready, '0);
    @(negedge clk);
    rst_n = 1'b1;

    run(30, 100, 0, 0, 0);
    run(60, 100, 100, 100, 0);
    run(400, 60, 45, 70, 0);
    run(400, 70, 70, 70, 1);

    // Drop reset while a block is in its fourth row.
    prob[0] = 100; prob[1] = 50; prob[2] = 50; inj_en = 0;
    waited = 0;
    while (!(m_owner >= 0 && m_rows == 3) && waited < 200) begin
      cycle();
      waited++;
    end
    chk("wait_row3", waited < 200, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst1");
    idle_inputs();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    run(60, 100, 100, 100, 0);
    run(300, 65, 65, 65, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
